// File: rtl/i2c_tx_arbiter.sv
// Round-robin arbiter sharing one I2C master among N_REQ requesters.
// Latches the winner's descriptor, runs the start/complete handshake and reports done/err.
module i2c_tx_arbiter #(
    parameter int                 N_REQ   = 4,
    parameter int                 TMO_W   = 16,
    parameter logic [TMO_W-1:0]   TMO_MAX = '1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [16*N_REQ-1:0]   i_add_sla,
    input  logic [16*N_REQ-1:0]   i_add_res,
    input  logic [N_REQ-1:0]      i_res_en,
    input  logic [2*N_REQ-1:0]    i_len_add,
    input  logic [3*N_REQ-1:0]    i_num_by,
    input  logic [64*N_REQ-1:0]   i_data_tx,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_done,
    output logic [N_REQ-1:0]      o_err,
    output logic                  o_busy,
    output logic                  m_en,
    output logic                  m_start,
    output logic [15:0]           m_add_sla,
    output logic [15:0]           m_add_res,
    output logic                  m_res_en,
    output logic [1:0]            m_len_add,
    output logic [2:0]            m_num_by,
    output logic [63:0]           m_data_tx,
    input  logic                  m_busy,
    input  logic                  m_ts,
    input  logic                  m_detect,
    input  logic                  m_err
);

    // state   | meaning
    // IDLE    | no owner; arbitrate among i_req from rr pointer
    // LAUNCH  | raise m_start, clear timeout counter
    // WAIT    | m_start held; collect errors; wait m_ts or timeout
    // RELEASE | m_start low; wait for master to drop m_ts
    // ABORT   | m_en low for 2 cycles to reset the master
    // DONE    | one-cycle o_done/o_err pulse; advance rr pointer
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_RELEASE, S_ABORT, S_DONE
    } state_t;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               sticky_q, sticky_d;
    logic               abort_q, abort_d;
    logic [15:0]        add_sla_q, add_sla_d;
    logic [15:0]        add_res_q, add_res_d;
    logic               res_en_q, res_en_d;
    logic [1:0]         len_add_q, len_add_d;
    logic [2:0]         num_by_q, num_by_d;
    logic [63:0]        data_tx_q, data_tx_d;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    int                 cand;
    logic [TMO_W-1:0]   tmo_inc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            rr_q      <= '0;
            tmo_q     <= '0;
            sticky_q  <= 1'b0;
            abort_q   <= 1'b0;
            add_sla_q <= '0;
            add_res_q <= '0;
            res_en_q  <= 1'b0;
            len_add_q <= '0;
            num_by_q  <= '0;
            data_tx_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            tmo_q     <= tmo_d;
            sticky_q  <= sticky_d;
            abort_q   <= abort_d;
            add_sla_q <= add_sla_d;
            add_res_q <= add_res_d;
            res_en_q  <= res_en_d;
            len_add_q <= len_add_d;
            num_by_q  <= num_by_d;
            data_tx_q <= data_tx_d;
        end
    end

    // First requesting index at or after rr pointer, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(rr_q) + i) % N_REQ;
            if (!win_vld && i_req[cand]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        tmo_d     = tmo_q;
        sticky_d  = sticky_q;
        abort_d   = abort_q;
        add_sla_d = add_sla_q;
        add_res_d = add_res_q;
        res_en_d  = res_en_q;
        len_add_d = len_add_q;
        num_by_d  = num_by_q;
        data_tx_d = data_tx_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    idx_d          = win_idx;
                    add_sla_d      = i_add_sla[16*win_idx +: 16];
                    add_res_d      = i_add_res[16*win_idx +: 16];
                    res_en_d       = i_res_en[win_idx];
                    len_add_d      = i_len_add[2*win_idx +: 2];
                    num_by_d       = i_num_by[3*win_idx +: 3];
                    data_tx_d      = i_data_tx[64*win_idx +: 64];
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_busy) begin
                    sticky_d = sticky_q | m_err | ~m_detect;
                end
                tmo_d = tmo_inc;
                if (m_ts) begin
                    state_d = S_RELEASE;
                end else if (tmo_inc == TMO_MAX) begin
                    sticky_d = 1'b1;
                    abort_d  = 1'b0;
                    state_d  = S_ABORT;
                end
            end
            S_RELEASE: begin
                if (!m_ts) begin
                    state_d = S_DONE;
                end
            end
            S_ABORT: begin
                abort_d = 1'b1;
                if (abort_q) begin
                    abort_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d    = '0;
                sticky_d = 1'b0;
                rr_d     = (idx_q == IDX_W'(N_REQ-1)) ? '0 : idx_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_gnt     = gnt_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = (state_q == S_DONE) ? gnt_q : '0;
    assign o_err     = (state_q == S_DONE && sticky_q) ? gnt_q : '0;
    assign m_start   = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign m_en      = (state_q != S_ABORT);
    assign m_add_sla = add_sla_q;
    assign m_add_res = add_res_q;
    assign m_res_en  = res_en_q;
    assign m_len_add = len_add_q;
    assign m_num_by  = num_by_q;
    assign m_data_tx = data_tx_q;

endmodule

// File: tb/tb_i2c_tx_arbiter.sv
// Directed bench for i2c_tx_arbiter with a small behavioural I2C master model.
module tb_i2c_tx_arbiter;

    localparam int N = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [N-1:0]      i_req;
    logic [16*N-1:0]   i_add_sla, i_add_res;
    logic [N-1:0]      i_res_en;
    logic [2*N-1:0]    i_len_add;
    logic [3*N-1:0]    i_num_by;
    logic [64*N-1:0]   i_data_tx;
    logic [N-1:0]      o_gnt, o_done, o_err;
    logic              o_busy, m_en, m_start, m_res_en;
    logic [15:0]       m_add_sla, m_add_res;
    logic [1:0]        m_len_add;
    logic [2:0]        m_num_by;
    logic [63:0]       m_data_tx;
    logic              m_busy, m_ts, m_detect, m_err;

    int  n_chk = 0;
    int  n_pass = 0;
    int  onehot_viol = 0;
    bit  model_nack = 1'b0;
    bit  model_hang = 1'b0;
    int  model_len = 20;
    int  mcnt = 0;

    i2c_tx_arbiter #(.N_REQ(N), .TMO_W(16), .TMO_MAX(16'd100)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
        .i_add_sla(i_add_sla), .i_add_res(i_add_res), .i_res_en(i_res_en),
        .i_len_add(i_len_add), .i_num_by(i_num_by), .i_data_tx(i_data_tx),
        .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
        .m_en(m_en), .m_start(m_start), .m_add_sla(m_add_sla), .m_add_res(m_add_res),
        .m_res_en(m_res_en), .m_len_add(m_len_add), .m_num_by(m_num_by),
        .m_data_tx(m_data_tx), .m_busy(m_busy), .m_ts(m_ts),
        .m_detect(m_detect), .m_err(m_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    // Master model: runs model_len cycles per start, optional NACK or hang.
    initial begin
        m_busy = 1'b0; m_ts = 1'b0; m_detect = 1'b1; m_err = 1'b0;
        forever begin
            @(negedge i_clk);
            m_detect = !model_nack;
            if (!m_en || !m_start) begin
                m_busy = 1'b0; m_ts = 1'b0; mcnt = 0;
            end else if (!m_ts) begin
                m_busy = 1'b1;
                mcnt++;
                if (!model_hang && mcnt >= model_len) begin
                    m_ts = 1'b1; m_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if ((o_gnt & (o_gnt - 1'b1)) != '0) onehot_viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    task automatic wait_done(output logic [N-1:0] d, output logic [N-1:0] e);
        d = '0; e = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            if (o_done != '0) begin
                d = o_done; e = o_err;
                break;
            end
        end
        @(negedge i_clk);
        check("done_width", 64'(o_done), 64'h0);
    endtask

    logic [N-1:0] d, e;
    int cnt;

    initial begin
        i_rst_n = 1'b0; i_req = '0;
        for (int k = 0; k < N; k++) begin
            i_add_sla[16*k +: 16] = 16'h0040 + 16'(16*k);
            i_add_res[16*k +: 16] = 16'h1000 + 16'(k);
            i_res_en[k]           = k[0];
            i_len_add[2*k +: 2]   = 2'(k);
            i_num_by[3*k +: 3]    = 3'(k + 1);
            i_data_tx[64*k +: 64] = {16{4'(k + 1)}};
        end
        repeat (3) @(negedge i_clk);
        check("rst_gnt", 64'(o_gnt), 64'h0);
        check("rst_done", 64'(o_done), 64'h0);
        check("rst_err", 64'(o_err), 64'h0);
        check("rst_busy", 64'(o_busy), 64'h0);
        check("rst_start", 64'(m_start), 64'h0);
        check("rst_en", 64'(m_en), 64'h1);
        check("rst_sla", 64'(m_add_sla), 64'h0);
        check("rst_data", m_data_tx, 64'h0);

        // single request from requester 1
        i_rst_n = 1'b1; i_req = 4'b0010;
        @(negedge i_clk);
        check("single_gnt", 64'(o_gnt), 64'h2);
        check("single_busy", 64'(o_busy), 64'h1);
        check("single_sla", 64'(m_add_sla), 64'h0050);
        check("single_res", 64'(m_add_res), 64'h1001);
        check("single_resen", 64'(m_res_en), 64'h1);
        check("single_len", 64'(m_len_add), 64'h1);
        check("single_numby", 64'(m_num_by), 64'h2);
        check("single_data", m_data_tx, 64'h2222_2222_2222_2222);
        repeat (5) @(negedge i_clk);
        check("single_start", 64'(m_start), 64'h1);
        wait_done(d, e);
        check("single_done", 64'(d), 64'h2);
        check("single_err", 64'(e), 64'h0);
        i_req = '0;
        @(negedge i_clk);

        // contention from a fresh rr pointer: order 0,1,2,3,0
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1; i_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("rr_gnt", 64'(o_gnt), 64'(4'b0001 << (i % 4)));
            wait_done(d, e);
            check("rr_done", 64'(d), 64'(4'b0001 << (i % 4)));
            check("rr_err", 64'(e), 64'h0);
            check("rr_gap", 64'(o_gnt), 64'h0);
        end
        i_req = '0;

        // NACK on requester 2, then requester 3 served cleanly
        model_nack = 1'b1; i_req = 4'b1100;
        @(negedge i_clk);
        check("nack_gnt", 64'(o_gnt), 64'h4);
        wait_done(d, e);
        check("nack_done", 64'(d), 64'h4);
        check("nack_err", 64'(e), 64'h4);
        model_nack = 1'b0; i_req = 4'b1000;
        @(negedge i_clk);
        check("after_nack_gnt", 64'(o_gnt), 64'h8);
        wait_done(d, e);
        check("after_nack_done", 64'(d), 64'h8);
        check("after_nack_err", 64'(e), 64'h0);
        i_req = '0;

        // descriptor stability and request drop while granted
        i_req = 4'b0001;
        @(negedge i_clk);
        check("stab_gnt", 64'(o_gnt), 64'h1);
        i_data_tx[63:0] = 64'hDEAD_BEEF_0000_0001;
        i_add_sla[15:0] = 16'hABCD;
        i_req = '0;
        repeat (5) @(negedge i_clk);
        check("stab_data", m_data_tx, 64'h1111_1111_1111_1111);
        check("stab_sla", 64'(m_add_sla), 64'h0040);
        check("stab_gnt_held", 64'(o_gnt), 64'h1);
        wait_done(d, e);
        check("stab_done", 64'(d), 64'h1);
        i_data_tx[63:0] = 64'h1111_1111_1111_1111;
        i_add_sla[15:0] = 16'h0040;

        // timeout: master never completes
        model_hang = 1'b1; i_req = 4'b0010;
        @(negedge i_clk);
        check("tmo_gnt", 64'(o_gnt), 64'h2);
        check("tmo_start", 64'(m_start), 64'h1);
        cnt = 0;
        while (m_en && cnt < 500) begin
            @(negedge i_clk);
            cnt++;
        end
        check("tmo_cycles", 64'(cnt), 64'd101);
        check("tmo_start_low", 64'(m_start), 64'h0);
        @(negedge i_clk);
        check("tmo_en_2nd", 64'(m_en), 64'h0);
        @(negedge i_clk);
        check("tmo_en_back", 64'(m_en), 64'h1);
        check("tmo_done", 64'(o_done), 64'h2);
        check("tmo_err", 64'(o_err), 64'h2);
        model_hang = 1'b0;
        @(negedge i_clk);
        check("tmo_done_width", 64'(o_done), 64'h0);
        i_req = '0;

        // reset during WAIT: rr pointer returns to 0
        i_req = 4'b0101;
        @(negedge i_clk);
        check("rstw_gnt", 64'(o_gnt), 64'h4);
        repeat (5) @(negedge i_clk);
        check("rstw_start", 64'(m_start), 64'h1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("rstw_start_low", 64'(m_start), 64'h0);
        check("rstw_gnt_clr", 64'(o_gnt), 64'h0);
        check("rstw_busy", 64'(o_busy), 64'h0);
        check("rstw_no_done", 64'(o_done), 64'h0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rstw_regnt", 64'(o_gnt), 64'h1);
        wait_done(d, e);
        check("rstw_done0", 64'(d), 64'h1);
        i_req = 4'b0100;
        @(negedge i_clk);
        check("rstw_gnt2", 64'(o_gnt), 64'h4);
        wait_done(d, e);
        check("rstw_done2", 64'(d), 64'h4);
        check("rstw_err2", 64'(e), 64'h0);
        i_req = '0;

        check("gnt_onehot", 64'(onehot_viol), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
